// File: rtl/ofm_write_ctrl.sv
// rtl/ofm_write_ctrl.sv - output feature-map writer: splits rows into 16-byte chunks and streams them to the buffer
module ofm_write_ctrl #(
    parameter int ADDR_WIDTH  = 19,
    parameter int INOUT_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [8:0]             ofm_width,
    input  logic [8:0]             ofm_height,
    input  logic [9:0]             num_ch,
    input  logic                   in_valid,
    input  logic [INOUT_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   we_b,
    output logic [ADDR_WIDTH-1:0]  addr_b,
    output logic [INOUT_WIDTH-1:0] din_b,
    output logic [4:0]             size,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [8:0]             col_q, col_d;
    logic [8:0]             row_q, row_d;
    logic [9:0]             ch_q, ch_d;
    logic [8:0]             width_q, width_d;
    logic [8:0]             height_q, height_d;
    logic [9:0]             nch_q, nch_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [INOUT_WIDTH-1:0] din_q, din_d;
    logic [4:0]             size_q, size_d;

    logic       accept;
    logic [9:0] remain;
    logic       last_col;
    logic       last_row;
    logic       last_ch;
    logic       job_empty;
    logic [4:0] chunk_len;

    // Chunk bookkeeping: the last chunk of a row carries whatever pixels remain (1..16).
    always_comb begin
        accept    = (state_q == RUN) && in_valid;
        remain    = {1'b0, width_q} - {1'b0, col_q};
        last_col  = (remain <= 10'd16);
        chunk_len = last_col ? remain[4:0] : 5'd16;
        last_row  = (row_q == height_q - 9'd1);
        last_ch   = (ch_q == nch_q - 10'd1);
        job_empty = (ofm_width == 9'd0) || (ofm_height == 9'd0) || (num_ch == 10'd0);
    end

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            ch_q     <= '0;
            width_q  <= '0;
            height_q <= '0;
            nch_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            size_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ch_q     <= ch_d;
            width_q  <= width_d;
            height_q <= height_d;
            nch_q    <= nch_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            size_q   <= size_d;
        end
    end

    // Next-state: start only honoured in IDLE; FINISH lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = job_empty ? FINISH : RUN;
                end
            end
            RUN: begin
                if (accept && last_col && last_row && last_ch) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, pointer and the registered write port; col innermost, then row, then channel.
    always_comb begin
        ptr_d    = ptr_q;
        col_d    = col_q;
        row_d    = row_q;
        ch_d     = ch_q;
        width_d  = width_q;
        height_d = height_q;
        nch_d    = nch_q;
        we_d     = accept;
        addr_d   = addr_q;
        din_d    = din_q;
        size_d   = size_q;
        if ((state_q == IDLE) && start) begin
            ptr_d    = base_addr;
            col_d    = '0;
            row_d    = '0;
            ch_d     = '0;
            width_d  = ofm_width;
            height_d = ofm_height;
            nch_d    = num_ch;
        end
        if (accept) begin
            addr_d = ptr_q;
            din_d  = in_data;
            size_d = chunk_len;
            // Rows and planes are packed back to back, so the pointer simply accumulates.
            ptr_d  = ptr_q + ADDR_WIDTH'(chunk_len);
            if (!last_col) begin
                col_d = col_q + 9'd16;
            end else begin
                col_d = '0;
                if (!last_row) begin
                    row_d = row_q + 9'd1;
                end else begin
                    row_d = '0;
                    ch_d  = ch_q + 10'd1;
                end
            end
        end
    end

    // Outputs: handshake and status decode from state only; write port straight from flops.
    always_comb begin
        in_ready = (state_q == RUN);
        busy     = (state_q != IDLE);
        done     = (state_q == FINISH);
        we_b     = we_q;
        addr_b   = addr_q;
        din_b    = din_q;
        size     = size_q;
    end

endmodule

// File: tb/tb_ofm_write_ctrl.sv
// tb/tb_ofm_write_ctrl.sv - scoreboard bench for ofm_write_ctrl
module tb_ofm_write_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [18:0]  base_addr;
    logic [8:0]   ofm_width;
    logic [8:0]   ofm_height;
    logic [9:0]   num_ch;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         we_b;
    logic [18:0]  addr_b;
    logic [127:0] din_b;
    logic [4:0]   size;
    logic         busy;
    logic         done;

    typedef struct {
        logic [18:0]  a;
        logic [4:0]   s;
        logic [127:0] d;
        logic         dn;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   ready_seen = 0;

    ofm_write_ctrl #(.ADDR_WIDTH(19), .INOUT_WIDTH(128)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .ofm_width(ofm_width), .ofm_height(ofm_height), .num_ch(num_ch),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .size(size),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every write the DUT presents is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_ready) ready_seen++;
            if (done) done_cnt++;
            if (we_b) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 128'(addr_b), 128'h7FFFFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("addr_b", 128'(addr_b), 128'(e.a));
                    chk("size", 128'(size), 128'(e.s));
                    chk("din_b", din_b, e.d);
                    chk("done_with_write", 128'(done), 128'(e.dn));
                end
            end
        end
    end

    // Offer one chunk and hold it until the DUT takes it (bounded wait).
    task automatic send_chunk(input logic [127:0] data);
        int n = 0;
        in_valid = 1'b1;
        in_data  = data;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [18:0] b, input int w, input int h, input int c);
        base_addr  = b;
        ofm_width  = 9'(w);
        ofm_height = 9'(h);
        num_ch     = 10'(c);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // One job: push expected writes via a row/chunk model, drive chunks, then check completion.
    task automatic job(input logic [18:0] b, input int w, input int h, input int c,
                       input bit gaps, input bit restart);
        logic [18:0]  ptr;
        logic [127:0] data;
        int           len;
        int           idx = 0;
        int           d0;
        exp_t         e;
        d0 = done_cnt;
        ready_seen = 0;
        ptr = b;
        pulse_start(b, w, h, c);
        if (w == 0 || h == 0 || c == 0) begin
            chk("empty_job_done", 128'(done), 128'd1);
            chk("empty_job_busy", 128'(busy), 128'd1);
        end
        for (int ch = 0; ch < c; ch++)
            for (int r = 0; r < h; r++)
                for (int col = 0; col < w; col += 16) begin
                    len  = (w - col >= 16) ? 16 : (w - col);
                    data = {$urandom, $urandom, $urandom, $urandom};
                    e.a  = ptr;
                    e.s  = 5'(len);
                    e.d  = data;
                    e.dn = (ch == c - 1) && (r == h - 1) && (col + 16 >= w);
                    exp_q.push_back(e);
                    send_chunk(data);
                    ptr = ptr + 19'(len);
                    idx++;
                    if (gaps || (restart && idx == 1)) begin
                        if (restart && idx == 1) begin
                            base_addr = 19'h55555;
                            ofm_width = 9'd3;
                            start     = 1'b1;
                        end
                        @(posedge clk); #1;
                        start = 1'b0;
                    end
                end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 128'(done_cnt - d0), 128'd1);
        chk("busy_after", 128'(busy), 128'd0);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        if (w == 0 || h == 0 || c == 0) chk("empty_job_no_ready", 128'(ready_seen), 128'd0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; base_addr = '0; ofm_width = '0; ofm_height = '0;
        num_ch = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we_b", 128'(we_b), 128'd0);
        chk("rst_addr_b", 128'(addr_b), 128'd0);
        chk("rst_din_b", din_b, 128'd0);
        chk("rst_size", 128'(size), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // in_valid while idle must not produce writes
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;

        job(19'h00100, 20, 2, 1, 1'b0, 1'b0);
        job(19'h02000, 32, 1, 3, 1'b0, 1'b0);
        job(19'h00300, 5, 0, 4, 1'b0, 1'b0);
        job(19'h00300, 0, 3, 1, 1'b0, 1'b0);
        job(19'h7FFF8, 16, 1, 2, 1'b0, 1'b0);
        job(19'h00100, 20, 2, 1, 1'b1, 1'b1);
        job(19'h00040, 17, 2, 2, 1'b1, 1'b0);

        // Reset after the second write of a 10-chunk job
        pulse_start(19'h01000, 160, 1, 1);
        for (int i = 0; i < 2; i++) begin
            e.a  = 19'h01000 + 19'(16 * i);
            e.s  = 5'd16;
            e.d  = {$urandom, $urandom, $urandom, $urandom};
            e.dn = 1'b0;
            exp_q.push_back(e);
            send_chunk(e.d);
        end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_we_b", 128'(we_b), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("postrst_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        chk("postrst_queue", 128'(exp_q.size()), 128'd0);

        job(19'h00500, 40, 1, 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
